sm_receiver: RTL and testbench

Capture and check block on the sorted-output side of the sorter. Consumes the `SM_valid`/`SM_addr`/`SM_data` stream, stores all elements in a local sorted buffer, and checks address sequencing, sort order and beat count. After a complete pass it raises `result_valid` and serves the buffer through a registered read port until it is cleared.

---
 rtl/sm_receiver.sv | 211 +++++++++++++++++++++
 tb/tb_sm_receiver.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/sm_receiver.sv
// sm_receiver: captures the sorter's sorted output stream into a local buffer,
// checks address sequencing, sort order and beat count, then serves the
// buffer through a one-cycle-latency registered read port until cleared.
module sm_receiver #(
  parameter int DATA_WIDTH       = 8,
  parameter int ELEMENT_NUM      = 16,
  parameter int LOG2_ELEMENT_NUM = 4,
  parameter int ASCENDING        = 1
) (
  input  logic                        clk_mn,
  input  logic                        rst,
  input  logic                        SM_valid,
  input  logic [LOG2_ELEMENT_NUM-1:0] SM_addr,
  input  logic [DATA_WIDTH-1:0]       SM_data,
  input  logic                        done,
  input  logic                        clear,
  input  logic                        rd_en,
  input  logic [LOG2_ELEMENT_NUM-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0]       rd_data,
  output logic                        rd_valid,
  output logic                        result_valid,
  output logic [LOG2_ELEMENT_NUM:0]   beat_cnt,
  output logic                        addr_err,
  output logic                        order_err,
  output logic                        count_err,
  output logic                        overrun
);

  localparam int unsigned CW = LOG2_ELEMENT_NUM + 1;
  localparam logic [CW-1:0] LP_NUM = CW'(ELEMENT_NUM);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_READY
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [DATA_WIDTH-1:0] r_mem [ELEMENT_NUM];
  logic [DATA_WIDTH-1:0] r_prev_data;
  logic [CW-1:0]         r_beat_cnt;
  logic                  r_done_d;
  logic                  r_addr_err;
  logic                  r_order_err;
  logic                  r_count_err;
  logic                  r_overrun;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  r_rd_valid;

  logic          w_capture_open;
  logic          w_read_open;
  logic          w_result_valid;
  logic          w_beat;
  logic          w_overrun_hit;
  logic [CW-1:0] w_cnt_inc;
  logic [CW-1:0] w_cnt_after;
  logic          w_last_beat;
  logic          w_done_rise;
  logic          w_addr_bad;
  logic          w_order_bad;
  logic          w_rd_in_range;

  // Datapath qualifiers; clear masks every update in its cycle.
  always_comb begin
    w_beat        = SM_valid & w_capture_open & ~clear;
    w_overrun_hit = SM_valid & w_read_open & ~clear;
    w_cnt_inc     = r_beat_cnt + 1'b1;
    w_cnt_after   = w_beat ? w_cnt_inc : r_beat_cnt;
    w_last_beat   = w_beat && (w_cnt_inc == LP_NUM);
    w_done_rise   = done & ~r_done_d;
    w_addr_bad    = (SM_addr != r_beat_cnt[LOG2_ELEMENT_NUM-1:0]);
    if (ASCENDING != 0) begin
      w_order_bad = (r_beat_cnt != '0) && (SM_data < r_prev_data);
    end else begin
      w_order_bad = (r_beat_cnt != '0) && (SM_data > r_prev_data);
    end
    w_rd_in_range = ({1'b0, rd_addr} < LP_NUM);
  end

  // State register.
  always_ff @(posedge clk_mn or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; the first beat may also be the last when ELEMENT_NUM is 1.
  always_comb begin
    w_state_next = r_state;
    if (clear) begin
      w_state_next = ST_IDLE;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_beat) begin
            w_state_next = w_last_beat ? ST_READY : ST_COLLECT;
          end
        end
        ST_COLLECT: begin
          if (w_last_beat) begin
            w_state_next = ST_READY;
          end
        end
        ST_READY: begin
          w_state_next = ST_READY;
        end
        default: begin
          w_state_next = ST_IDLE;
        end
      endcase
    end
  end

  // State-decoded outputs and enables.
  always_comb begin
    w_capture_open = 1'b0;
    w_read_open    = 1'b0;
    w_result_valid = 1'b0;
    unique case (r_state)
      ST_IDLE:    w_capture_open = 1'b1;
      ST_COLLECT: w_capture_open = 1'b1;
      ST_READY: begin
        w_read_open    = 1'b1;
        w_result_valid = 1'b1;
      end
      default: ;
    endcase
  end

  // Done edge detector; follows the raw level even across clear so a done
  // held high through a clear does not register a fresh rise.
  always_ff @(posedge clk_mn or posedge rst) begin
    if (rst) begin
      r_done_d <= 1'b0;
    end else begin
      r_done_d <= done;
    end
  end

  // Beat counter, previous-data register and sticky error flags.
  always_ff @(posedge clk_mn or posedge rst) begin
    if (rst) begin
      r_beat_cnt  <= '0;
      r_prev_data <= '0;
      r_addr_err  <= 1'b0;
      r_order_err <= 1'b0;
      r_count_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else if (clear) begin
      r_beat_cnt  <= '0;
      r_addr_err  <= 1'b0;
      r_order_err <= 1'b0;
      r_count_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_beat) begin
        r_beat_cnt  <= w_cnt_inc;
        r_prev_data <= SM_data;
        if (w_addr_bad) begin
          r_addr_err <= 1'b1;
        end
        if (w_order_bad) begin
          r_order_err <= 1'b1;
        end
      end
      if (w_overrun_hit) begin
        r_overrun <= 1'b1;
      end
      // Judged against the post-beat count so a rise alongside the final beat is legal.
      if (w_done_rise && (w_cnt_after != LP_NUM)) begin
        r_count_err <= 1'b1;
      end
    end
  end

  // Capture buffer, addressed by the internal beat counter; not reset or cleared.
  always_ff @(posedge clk_mn) begin
    if (w_beat) begin
      r_mem[r_beat_cnt[LOG2_ELEMENT_NUM-1:0]] <= SM_data;
    end
  end

  // Registered read port, live only in READY; out-of-range addresses return zero.
  always_ff @(posedge clk_mn or posedge rst) begin
    if (rst) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else if (clear) begin
      r_rd_valid <= 1'b0;
    end else if (rd_en && w_read_open) begin
      r_rd_valid <= 1'b1;
      r_rd_data  <= w_rd_in_range ? r_mem[rd_addr] : '0;
    end else begin
      r_rd_valid <= 1'b0;
    end
  end

  assign rd_data      = r_rd_data;
  assign rd_valid     = r_rd_valid;
  assign result_valid = w_result_valid;
  assign beat_cnt     = r_beat_cnt;
  assign addr_err     = r_addr_err;
  assign order_err    = r_order_err;
  assign count_err    = r_count_err;
  assign overrun      = r_overrun;

endmodule

// File: tb/tb_sm_receiver.sv
// Directed self-checking bench for sm_receiver (default parameters).
module tb_sm_receiver;

  logic       clk_mn = 1'b0;
  logic       rst;
  logic       SM_valid;
  logic [3:0] SM_addr;
  logic [7:0] SM_data;
  logic       done;
  logic       clear;
  logic       rd_en;
  logic [3:0] rd_addr;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       result_valid;
  logic [4:0] beat_cnt;
  logic       addr_err;
  logic       order_err;
  logic       count_err;
  logic       overrun;

  int checks   = 0;
  int failures = 0;

  logic [7:0] asc [16] = '{8'd3, 8'd5, 8'd5, 8'd9, 8'd12, 8'd20, 8'd20, 8'd33,
                           8'd40, 8'd41, 8'd50, 8'd77, 8'd90, 8'd128, 8'd200, 8'd255};
  logic [7:0] gapd [8] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd1, 8'd5, 8'd6, 8'd7};

  sm_receiver #(
    .DATA_WIDTH      (8),
    .ELEMENT_NUM     (16),
    .LOG2_ELEMENT_NUM(4),
    .ASCENDING       (1)
  ) dut (
    .clk_mn      (clk_mn),
    .rst         (rst),
    .SM_valid    (SM_valid),
    .SM_addr     (SM_addr),
    .SM_data     (SM_data),
    .done        (done),
    .clear       (clear),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .result_valid(result_valid),
    .beat_cnt    (beat_cnt),
    .addr_err    (addr_err),
    .order_err   (order_err),
    .count_err   (count_err),
    .overrun     (overrun)
  );

  always #5 clk_mn = ~clk_mn;

  task automatic tick();
    @(posedge clk_mn);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [3:0] a, input logic [7:0] d);
    SM_valid = 1'b1;
    SM_addr  = a;
    SM_data  = d;
    tick();
    SM_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; SM_valid = 1'b0; SM_addr = '0; SM_data = '0;
    done = 1'b0; clear = 1'b0; rd_en = 1'b0; rd_addr = '0;
    tick();
    tick();

    // Reset state
    chk("rst_rd_data", rd_data, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_result_valid", result_valid, 0);
    chk("rst_beat_cnt", beat_cnt, 0);
    chk("rst_flags", {addr_err, order_err, count_err, overrun}, 0);
    rst = 1'b0;
    tick();

    // Clean ascending pass
    for (int i = 0; i < 16; i++) begin
      beat(4'(i), asc[i]);
      chk("asc_cnt", beat_cnt, i + 1);
      chk("asc_rv", result_valid, (i == 15) ? 1 : 0);
    end
    // Held extra beat from the sorter with done rising together
    SM_valid = 1'b1; SM_addr = 4'd15; SM_data = 8'd255; done = 1'b1;
    tick();
    SM_valid = 1'b0;
    chk("asc_overrun", overrun, 1);
    chk("asc_cnt_hold", beat_cnt, 16);
    chk("asc_order_err", order_err, 0);
    chk("asc_addr_err", addr_err, 0);
    chk("asc_count_err", count_err, 0);
    chk("asc_rv_hold", result_valid, 1);

    // Back-to-back reads
    for (int i = 0; i < 16; i++) begin
      rd_en = 1'b1; rd_addr = 4'(i);
      tick();
      chk("rd_valid", rd_valid, 1);
      chk("rd_data", rd_data, asc[i]);
    end
    rd_en = 1'b0;
    tick();
    chk("rd_valid_drop", rd_valid, 0);
    chk("rd_data_hold", rd_data, 8'd255);

    // Clear in READY with simultaneous read
    clear = 1'b1; rd_en = 1'b1; rd_addr = 4'd3;
    tick();
    clear = 1'b0;
    chk("clr_rv", result_valid, 0);
    chk("clr_rd_valid", rd_valid, 0);
    chk("clr_rd_data", rd_data, 8'd255);
    chk("clr_cnt", beat_cnt, 0);
    chk("clr_flags", {addr_err, order_err, count_err, overrun}, 0);
    tick();
    chk("idle_rd_valid", rd_valid, 0);
    chk("idle_rd_data", rd_data, 8'd255);
    rd_en = 1'b0; done = 1'b0;
    tick();

    // Order violation: 10 then 7 at addresses 4,5; first beat below stale prev is legal
    for (int i = 0; i < 16; i++) begin
      logic [7:0] d;
      if (i < 4) d = 8'(2 * i);
      else if (i == 4) d = 8'd10;
      else if (i == 5) d = 8'd7;
      else d = 8'(14 + i);
      beat(4'(i), d);
      chk("ord_err", order_err, (i >= 5) ? 1 : 0);
    end
    chk("ord_rv", result_valid, 1);
    chk("ord_addr_err", addr_err, 0);
    clear = 1'b1;
    tick();
    clear = 1'b0;

    // Address skip, then early done after 10 beats
    beat(4'd0, 8'd11);
    beat(4'd1, 8'd22);
    chk("skip_ok", addr_err, 0);
    beat(4'd3, 8'd33);
    chk("skip_err", addr_err, 1);
    for (int i = 3; i < 10; i++) beat(4'(i + 1), 8'(40 + i));
    done = 1'b1;
    tick();
    chk("early_done_err", count_err, 1);
    chk("early_done_state", result_valid, 0);
    chk("early_done_cnt", beat_cnt, 10);
    for (int i = 10; i < 16; i++) beat(4'(i + 1), 8'(40 + i));
    chk("skip_rv", result_valid, 1);
    chk("skip_count_err_sticky", count_err, 1);
    rd_en = 1'b1; rd_addr = 4'd2;
    tick();
    chk("skip_mem2", rd_data, 8'd33);
    rd_addr = 4'd3;
    tick();
    chk("skip_mem3", rd_data, 8'd43);
    rd_en = 1'b0; done = 1'b0; clear = 1'b1;
    tick();
    clear = 1'b0;

    // Gapped beats then asynchronous reset mid-pass
    for (int i = 0; i < 8; i++) begin
      beat(4'(i), gapd[i]);
      chk("gap_cnt", beat_cnt, i + 1);
      tick();
      tick();
      chk("gap_hold", beat_cnt, i + 1);
    end
    chk("gap_order_err", order_err, 1);
    chk("gap_addr_err", addr_err, 0);
    rst = 1'b1;
    #1;
    chk("arst_cnt", beat_cnt, 0);
    chk("arst_rd_data", rd_data, 0);
    chk("arst_flags", {addr_err, order_err, count_err, overrun, result_valid, rd_valid}, 0);
    #1;
    rst = 1'b0;
    tick();

    // Fresh clean pass after reset
    for (int i = 0; i < 16; i++) beat(4'(i), asc[i]);
    chk("fresh_rv", result_valid, 1);
    chk("fresh_cnt", beat_cnt, 16);
    chk("fresh_flags", {addr_err, order_err, count_err, overrun}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
